// File: rtl/exc_commit_ctrl_if.sv
// Commit-stage bundle: WB instruction, csr update strobes/data and fetch redirect handshake.
// The controller uses the slave modport; the surrounding pipeline/csr/fetch side uses master.
interface exc_commit_ctrl_if;
   logic        wb_valid;
   logic        wb_ready;
   logic [31:0] wb_pc_in;
   logic        wb_ex_req;
   logic [5:0]  wb_ecode_in;
   logic [8:0]  wb_esubcode_in;
   logic [31:0] wb_vaddr_in;
   logic        wb_ertn;
   logic        wb_csr_we_in;
   logic [13:0] wb_csr_num_in;
   logic [31:0] wb_csr_wmask_in;
   logic [31:0] wb_csr_wvalue_in;
   logic        has_int;
   logic [31:0] csr_eentry_data;
   logic [31:0] csr_era_pc;
   logic        wb_ex;
   logic        ertn_flush;
   logic [31:0] wb_pc;
   logic [31:0] wb_vaddr;
   logic [5:0]  wb_ecode;
   logic [8:0]  wb_esubcode;
   logic        csr_we;
   logic [13:0] csr_num;
   logic [31:0] csr_wmask;
   logic [31:0] csr_wvalue;
   logic        pipe_flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        redirect_ready;

   modport slave (
      input  wb_valid, wb_pc_in, wb_ex_req, wb_ecode_in, wb_esubcode_in, wb_vaddr_in,
      input  wb_ertn, wb_csr_we_in, wb_csr_num_in, wb_csr_wmask_in, wb_csr_wvalue_in,
      input  has_int, csr_eentry_data, csr_era_pc, redirect_ready,
      output wb_ready, wb_ex, ertn_flush, wb_pc, wb_vaddr, wb_ecode, wb_esubcode,
      output csr_we, csr_num, csr_wmask, csr_wvalue, pipe_flush, redirect_valid, redirect_pc
   );

   modport master (
      output wb_valid, wb_pc_in, wb_ex_req, wb_ecode_in, wb_esubcode_in, wb_vaddr_in,
      output wb_ertn, wb_csr_we_in, wb_csr_num_in, wb_csr_wmask_in, wb_csr_wvalue_in,
      output has_int, csr_eentry_data, csr_era_pc, redirect_ready,
      input  wb_ready, wb_ex, ertn_flush, wb_pc, wb_vaddr, wb_ecode, wb_esubcode,
      input  csr_we, csr_num, csr_wmask, csr_wvalue, pipe_flush, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/exc_commit_ctrl.sv
// Commit-stage exception/interrupt controller: picks the retire outcome, strobes csr, redirects fetch.
// Define EXC_COMMIT_CTRL_STATS_EN to add the exc_cnt/int_cnt commit counters.
module exc_commit_ctrl #(
   parameter logic [5:0] INT_ECODE    = 6'h00,
   parameter logic [8:0] INT_ESUBCODE = 9'h000
) (
   input  logic              clk,
   input  logic              reset,
   exc_commit_ctrl_if.slave  bus
`ifdef EXC_COMMIT_CTRL_STATS_EN
   ,
   output logic [31:0]       exc_cnt,
   output logic [31:0]       int_cnt
`endif
);

   typedef enum logic [0:0] {StIdle, StRedir} state_e;

   state_e      state_q;
   logic        redirect_valid_q;
   logic        pipe_flush_q;
   logic        wb_ready_q;
   logic [31:0] redirect_pc_q;

   logic        commit;
   logic        take_int;
   logic        take_exc;
   logic        take_ertn;
   logic        take_csrw;
   logic        take_redir;
   logic [31:0] redir_target;

   // Nothing commits during reset, even if the FSM was idle.
   always_comb begin
      commit       = !reset && (state_q == StIdle) && bus.wb_valid;
      take_int     = commit && bus.has_int;
      take_exc     = commit && !bus.has_int && bus.wb_ex_req;
      take_ertn    = commit && !bus.has_int && !bus.wb_ex_req && bus.wb_ertn;
      take_csrw    = commit && !bus.has_int && !bus.wb_ex_req && !bus.wb_ertn && bus.wb_csr_we_in;
      take_redir   = take_int || take_exc || take_ertn;
      redir_target = take_ertn ? bus.csr_era_pc : bus.csr_eentry_data;
   end

   always_comb begin
      bus.wb_ready       = wb_ready_q;
      bus.wb_ex          = take_int || take_exc;
      bus.ertn_flush     = take_ertn;
      bus.wb_pc          = bus.wb_pc_in;
      bus.wb_vaddr       = bus.wb_vaddr_in;
      bus.wb_ecode       = bus.has_int ? INT_ECODE : bus.wb_ecode_in;
      bus.wb_esubcode    = bus.has_int ? INT_ESUBCODE : bus.wb_esubcode_in;
      bus.csr_we         = take_csrw;
      bus.csr_num        = bus.wb_csr_num_in;
      bus.csr_wmask      = bus.wb_csr_wmask_in;
      bus.csr_wvalue     = bus.wb_csr_wvalue_in;
      bus.pipe_flush     = pipe_flush_q;
      bus.redirect_valid = redirect_valid_q;
      bus.redirect_pc    = redirect_pc_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= StIdle;
         redirect_valid_q <= 1'b0;
         pipe_flush_q     <= 1'b0;
         wb_ready_q       <= 1'b1;
         redirect_pc_q    <= 32'h0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (take_redir) begin
                  state_q          <= StRedir;
                  redirect_valid_q <= 1'b1;
                  pipe_flush_q     <= 1'b1;
                  wb_ready_q       <= 1'b0;
                  redirect_pc_q    <= redir_target;
               end
            end
            StRedir: begin
               // redirect_pc_q is left untouched so it stays stable until fetch accepts it.
               if (bus.redirect_ready) begin
                  state_q          <= StIdle;
                  redirect_valid_q <= 1'b0;
                  pipe_flush_q     <= 1'b0;
                  wb_ready_q       <= 1'b1;
               end
            end
            default: begin
               state_q          <= StIdle;
               redirect_valid_q <= 1'b0;
               pipe_flush_q     <= 1'b0;
               wb_ready_q       <= 1'b1;
            end
         endcase
      end
   end

`ifdef EXC_COMMIT_CTRL_STATS_EN
   logic [31:0] exc_cnt_q;
   logic [31:0] int_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         exc_cnt_q <= 32'h0;
         int_cnt_q <= 32'h0;
      end else begin
         if (take_exc) exc_cnt_q <= exc_cnt_q + 32'd1;
         if (take_int) int_cnt_q <= int_cnt_q + 32'd1;
      end
   end

   assign exc_cnt = exc_cnt_q;
   assign int_cnt = int_cnt_q;
`endif

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Self-checking bench for exc_commit_ctrl: directed scenarios plus randomized traffic vs a
// behavioural model of commit outcome priority and the redirect handshake.
module tb_exc_commit_ctrl;

   localparam logic [5:0] IntEcode    = 6'h00;
   localparam logic [8:0] IntEsubcode = 9'h000;

   logic clk = 1'b0;
   logic reset;
   exc_commit_ctrl_if bus ();
`ifdef EXC_COMMIT_CTRL_STATS_EN
   logic [31:0] exc_cnt;
   logic [31:0] int_cnt;
`endif

   exc_commit_ctrl #(
      .INT_ECODE    (IntEcode),
      .INT_ESUBCODE (IntEsubcode)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef EXC_COMMIT_CTRL_STATS_EN
      ,
      .exc_cnt (exc_cnt),
      .int_cnt (int_cnt)
`endif
   );

   always #5 clk = ~clk;

   int tests_run = 0;
   int tests_failed = 0;

   // Model state: whether a redirect is outstanding, its PC, and commit counters.
   bit          m_redir;
   logic [31:0] m_rpc;
   logic [31:0] m_exc;
   logic [31:0] m_int;

   logic e_int, e_exc, e_ertn, e_csrw;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Outcome of the current cycle from the priority rules.
   task automatic decide();
      bit commit;
      commit = !reset && !m_redir && bus.wb_valid;
      e_int  = commit && bus.has_int;
      e_exc  = commit && !bus.has_int && bus.wb_ex_req;
      e_ertn = commit && !bus.has_int && !bus.wb_ex_req && bus.wb_ertn;
      e_csrw = commit && !bus.has_int && !bus.wb_ex_req && !bus.wb_ertn && bus.wb_csr_we_in;
   endtask

   task automatic check_model();
      decide();
      chk("wb_ready", 32'(bus.wb_ready), 32'(!m_redir));
      chk("redirect_valid", 32'(bus.redirect_valid), 32'(m_redir));
      chk("pipe_flush", 32'(bus.pipe_flush), 32'(m_redir));
      if (m_redir) chk("redirect_pc", bus.redirect_pc, m_rpc);
      chk("wb_ex", 32'(bus.wb_ex), 32'(e_int || e_exc));
      chk("ertn_flush", 32'(bus.ertn_flush), 32'(e_ertn));
      chk("csr_we", 32'(bus.csr_we), 32'(e_csrw));
      if (e_int || e_exc) begin
         chk("wb_pc", bus.wb_pc, bus.wb_pc_in);
         chk("wb_ecode", 32'(bus.wb_ecode), 32'(e_int ? IntEcode : bus.wb_ecode_in));
         chk("wb_esubcode", 32'(bus.wb_esubcode), 32'(e_int ? IntEsubcode : bus.wb_esubcode_in));
      end
      if (e_exc) chk("wb_vaddr", bus.wb_vaddr, bus.wb_vaddr_in);
      if (e_csrw) begin
         chk("csr_num", 32'(bus.csr_num), 32'(bus.wb_csr_num_in));
         chk("csr_wmask", bus.csr_wmask, bus.wb_csr_wmask_in);
         chk("csr_wvalue", bus.csr_wvalue, bus.wb_csr_wvalue_in);
      end
`ifdef EXC_COMMIT_CTRL_STATS_EN
      chk("exc_cnt", exc_cnt, m_exc);
      chk("int_cnt", int_cnt, m_int);
`endif
   endtask

   task automatic model_update();
      decide();
      if (reset) begin
         m_redir = 1'b0;
         m_rpc   = 32'h0;
         m_exc   = 32'h0;
         m_int   = 32'h0;
      end else if (!m_redir) begin
         if (e_int || e_exc || e_ertn) begin
            m_redir = 1'b1;
            m_rpc   = e_ertn ? bus.csr_era_pc : bus.csr_eentry_data;
         end
         if (e_exc) m_exc = m_exc + 32'd1;
         if (e_int) m_int = m_int + 32'd1;
      end else if (bus.redirect_ready) begin
         m_redir = 1'b0;
      end
   endtask

   task automatic settle();
      #1;
      check_model();
   endtask

   task automatic advance();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.wb_valid         = 1'b0;
      bus.wb_pc_in         = 32'h0;
      bus.wb_ex_req        = 1'b0;
      bus.wb_ecode_in      = 6'h0;
      bus.wb_esubcode_in   = 9'h0;
      bus.wb_vaddr_in      = 32'h0;
      bus.wb_ertn          = 1'b0;
      bus.wb_csr_we_in     = 1'b0;
      bus.wb_csr_num_in    = 14'h0;
      bus.wb_csr_wmask_in  = 32'h0;
      bus.wb_csr_wvalue_in = 32'h0;
      bus.has_int          = 1'b0;
      bus.csr_eentry_data  = 32'h0;
      bus.csr_era_pc       = 32'h0;
      bus.redirect_ready   = 1'b0;
   endtask

   task automatic rand_inputs();
      reset                = ($urandom_range(0, 99) == 0);
      bus.wb_valid         = ($urandom_range(0, 9) < 7);
      bus.has_int          = ($urandom_range(0, 15) == 0);
      bus.wb_ex_req        = ($urandom_range(0, 7) == 0);
      bus.wb_ertn          = ($urandom_range(0, 7) == 0);
      bus.wb_csr_we_in     = ($urandom_range(0, 1) == 1);
      bus.wb_pc_in         = $urandom;
      bus.wb_ecode_in      = 6'($urandom);
      bus.wb_esubcode_in   = 9'($urandom);
      bus.wb_vaddr_in      = $urandom;
      bus.wb_csr_num_in    = 14'($urandom);
      bus.wb_csr_wmask_in  = $urandom;
      bus.wb_csr_wvalue_in = $urandom;
      bus.csr_eentry_data  = $urandom;
      bus.csr_era_pc       = $urandom;
      bus.redirect_ready   = ($urandom_range(0, 1) == 1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      reset = 1'b1;
      @(posedge clk);
      model_update();
      @(negedge clk);
      #1;
      chk("rst_wb_ready", 32'(bus.wb_ready), 32'd1);
      chk("rst_redirect_valid", 32'(bus.redirect_valid), 32'd0);
      chk("rst_pipe_flush", 32'(bus.pipe_flush), 32'd0);
      chk("rst_redirect_pc", bus.redirect_pc, 32'h0);
`ifdef EXC_COMMIT_CTRL_STATS_EN
      chk("rst_exc_cnt", exc_cnt, 32'h0);
      chk("rst_int_cnt", int_cnt, 32'h0);
`endif
      advance();
      reset = 1'b0;

      // Plain CSR write, then a back-to-back second one.
      bus.wb_valid = 1'b1; bus.wb_csr_we_in = 1'b1; bus.wb_csr_num_in = 14'h30;
      bus.wb_csr_wmask_in = 32'hffffffff; bus.wb_csr_wvalue_in = 32'h1234;
      bus.redirect_ready = 1'b1;
      settle();
      chk("csrw_we", 32'(bus.csr_we), 32'd1);
      chk("csrw_num", 32'(bus.csr_num), 32'h30);
      chk("csrw_value", bus.csr_wvalue, 32'h1234);
      advance();
      bus.wb_csr_num_in = 14'h31; bus.wb_csr_wvalue_in = 32'h5678;
      settle();
      chk("csrw2_we", 32'(bus.csr_we), 32'd1);
      chk("csrw2_ready", 32'(bus.wb_ready), 32'd1);
      chk("csrw2_redirect", 32'(bus.redirect_valid), 32'd0);
      advance();
      idle_inputs();
      settle();
      chk("csrw_done", 32'(bus.csr_we), 32'd0);
      advance();

      // Exception with a 3-cycle fetch stall; WB keeps presenting it meanwhile.
      bus.csr_eentry_data = 32'h1c008000; bus.wb_valid = 1'b1; bus.wb_ex_req = 1'b1;
      bus.wb_ecode_in = 6'h0b; bus.wb_pc_in = 32'h1c000100; bus.wb_vaddr_in = 32'h0000beef;
      settle();
      chk("exc_wb_ex", 32'(bus.wb_ex), 32'd1);
      chk("exc_ecode", 32'(bus.wb_ecode), 32'h0b);
      chk("exc_pc", bus.wb_pc, 32'h1c000100);
      advance();
      bus.csr_eentry_data = 32'hdeadbeef;
      bus.has_int = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         bus.redirect_ready = (i == 4);
         settle();
         chk("exc_redir_valid", 32'(bus.redirect_valid), 32'd1);
         chk("exc_redir_pc", bus.redirect_pc, 32'h1c008000);
         chk("exc_stall_ready", 32'(bus.wb_ready), 32'd0);
         chk("exc_no_strobe", 32'(bus.wb_ex), 32'd0);
         advance();
      end
      idle_inputs();
      settle();
      chk("exc_back_idle", 32'(bus.redirect_valid), 32'd0);
      chk("exc_back_ready", 32'(bus.wb_ready), 32'd1);
      advance();

      // ERTN with immediate accept; wb_ex_req+wb_ertn afterwards lets EXC win.
      bus.csr_era_pc = 32'h1c000104; bus.wb_valid = 1'b1; bus.wb_ertn = 1'b1;
      settle();
      chk("ertn_flush", 32'(bus.ertn_flush), 32'd1);
      chk("ertn_no_ex", 32'(bus.wb_ex), 32'd0);
      advance();
      bus.redirect_ready = 1'b1;
      settle();
      chk("ertn_redir_pc", bus.redirect_pc, 32'h1c000104);
      advance();
      bus.wb_ex_req = 1'b1; bus.csr_eentry_data = 32'h1c00a000;
      settle();
      chk("ertn_idle_ready", 32'(bus.wb_ready), 32'd1);
      chk("exc_over_ertn_flush", 32'(bus.ertn_flush), 32'd0);
      chk("exc_over_ertn_ex", 32'(bus.wb_ex), 32'd1);
      advance();
      idle_inputs();
      bus.redirect_ready = 1'b1;
      settle();
      advance();

      // has_int without a valid instruction does nothing; then INT beats EXC and CSRW.
      bus.has_int = 1'b1;
      settle();
      chk("int_novalid", 32'(bus.wb_ex), 32'd0);
      advance();
      bus.wb_valid = 1'b1; bus.wb_ex_req = 1'b1; bus.wb_ecode_in = 6'h0b;
      bus.wb_csr_we_in = 1'b1; bus.csr_eentry_data = 32'h1c00c000;
      settle();
      chk("prio_wb_ex", 32'(bus.wb_ex), 32'd1);
      chk("prio_ecode", 32'(bus.wb_ecode), 32'h00);
      chk("prio_csr_we", 32'(bus.csr_we), 32'd0);
      advance();
      idle_inputs();
      bus.redirect_ready = 1'b1;
      settle();
      advance();

      // Reset in the middle of a redirect.
      bus.wb_valid = 1'b1; bus.wb_ex_req = 1'b1; bus.csr_eentry_data = 32'h1c00e000;
      settle();
      advance();
      settle();
      advance();
      reset = 1'b1;
      settle();
      advance();
      reset = 1'b0;
      idle_inputs();
      settle();
      chk("rstmid_redir_valid", 32'(bus.redirect_valid), 32'd0);
      chk("rstmid_ready", 32'(bus.wb_ready), 32'd1);
`ifdef EXC_COMMIT_CTRL_STATS_EN
      chk("rstmid_exc_cnt", exc_cnt, 32'h0);
`endif
      advance();

`ifdef EXC_COMMIT_CTRL_STATS_EN
      force dut.int_cnt_q = 32'hffffffff;
      #1;
      release dut.int_cnt_q;
      m_int = 32'hffffffff;
      bus.wb_valid = 1'b1; bus.has_int = 1'b1;
      settle();
      advance();
      idle_inputs();
      bus.redirect_ready = 1'b1;
      #1;
      chk("int_cnt_wrap", int_cnt, 32'h0);
      settle();
      advance();
`endif

      for (int n = 0; n < 2000; n++) begin
         rand_inputs();
         settle();
         advance();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/exc_commit_ctrl.md
# exc_commit_ctrl

Commit-stage exception/interrupt controller between the WB stage and the `csr` register file. It decides each retiring instruction's outcome: interrupt, synchronous exception, `ertn` return, CSR write or plain retire. It drives the `csr` update strobes for that outcome. It then runs a flush/redirect handshake with the fetch stage, holding WB stalled until fetch accepts the new PC.

## Interface
Parameters:
- `INT_ECODE`, 6'h00: ecode written for interrupts.
- `INT_ESUBCODE`, 9'h000: esubcode written for interrupts.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `wb_valid`  in  1  WB holds a retiring instruction
- `wb_ready`  out  1  controller accepts the WB instruction this cycle
- `wb_pc_in`  in  32  PC of the WB instruction
- `wb_ex_req`  in  1  WB instruction raised a synchronous exception
- `wb_ecode_in`  in  6  ecode of that exception
- `wb_esubcode_in`  in  9  esubcode of that exception
- `wb_vaddr_in`  in  32  faulting data address
- `wb_ertn`  in  1  WB instruction is `ertn`
- `wb_csr_we_in`  in  1  WB instruction writes a CSR
- `wb_csr_num_in`  in  14  CSR number
- `wb_csr_wmask_in`  in  32  CSR write mask
- `wb_csr_wvalue_in`  in  32  CSR write value
- `has_int`  in  1  pending enabled interrupt, from `csr`
- `csr_eentry_data`  in  32  exception entry, from `csr`
- `csr_era_pc`  in  32  return address, from `csr`
- `wb_ex`  out  1  exception commit strobe, to `csr`
- `ertn_flush`  out  1  `ertn` commit strobe, to `csr`
- `wb_pc`  out  32  PC forwarded to `csr`
- `wb_vaddr`  out  32  vaddr forwarded to `csr`
- `wb_ecode`  out  6  ecode forwarded to `csr`
- `wb_esubcode`  out  9  esubcode forwarded to `csr`
- `csr_we`  out  1  CSR write strobe
- `csr_num`  out  14  CSR number forwarded
- `csr_wmask`  out  32  CSR write mask forwarded
- `csr_wvalue`  out  32  CSR write value forwarded
- `pipe_flush`  out  1  kill all younger instructions in IF–MEM
- `redirect_valid`  out  1  new fetch PC valid
- `redirect_pc`  out  32  new fetch PC
- `redirect_ready`  in  1  fetch accepts `redirect_pc`

## Operation
- FSM states:
  - IDLE (reset state).
  - REDIR: `pipe_flush`=1, `redirect_valid`=1, `wb_ready`=0.
- Commit: a cycle with state IDLE and `wb_valid`=1. `wb_ready` is 1 in IDLE.
- Priority at commit, highest first:
  1. INT: `has_int`=1. The WB instruction is not executed. `wb_ex`=1; ecode/esubcode = `INT_ECODE`/`INT_ESUBCODE`; `wb_pc`=`wb_pc_in`. Target = `csr_eentry_data`.
  2. EXC: `wb_ex_req`=1. `wb_ex`=1; ecode/esubcode/vaddr taken from the inputs. Target = `csr_eentry_data`.
  3. ERTN: `wb_ertn`=1. `ertn_flush`=1. Target = `csr_era_pc`.
  4. CSRW: `wb_csr_we_in`=1. `csr_we`=1 with num/mask/value forwarded. No flush; stay in IDLE.
  5. Otherwise: retire, no strobes.
- INT/EXC/ERTN suppress `csr_we` even if `wb_csr_we_in`=1.
- Data outputs (`wb_pc`, `wb_vaddr`, `wb_ecode`, `wb_esubcode`, `csr_num`, `csr_wmask`, `csr_wvalue`) are combinational passthroughs. They are meaningful only while the matching strobe is high.
- Strobes (`wb_ex`, `ertn_flush`, `csr_we`) are combinational, one cycle, commit cycle only. They are 0 outside IDLE and when `wb_valid`=0.
- INT/EXC/ERTN latch the target into `redirect_pc` at the commit edge; the FSM moves IDLE→REDIR.
- REDIR→IDLE on the edge where `redirect_ready`=1. `redirect_pc` holds stable until then.
- `has_int`, `wb_valid` and all WB inputs are ignored in REDIR. WB holds its instruction because `wb_ready`=0.

## Timing
- Reset values:
  - state IDLE; `redirect_valid`=0, `pipe_flush`=0, `redirect_pc`=0.
  - `wb_ready`=1; all strobes 0.
  - Stats counters (if compiled in) = 0.
- Commit at cycle T; `csr` captures the update at the end of T. `redirect_valid`/`pipe_flush` rise at T+1.
- `redirect_ready`=1 at T+1 → IDLE at T+2. Earliest next commit is T+2.
- `redirect_ready` held low for N cycles → REDIR lasts N+1 cycles; `redirect_pc` is constant throughout.
- `redirect_ready` is ignored in IDLE.
- Back-to-back CSRW commits: one per cycle, no bubbles.
- `wb_ex_req` and `wb_ertn` together: EXC wins; `ertn_flush`=0.
- `has_int` with `wb_valid`=0: no action. The interrupt is taken on the next valid commit.
- Reset asserted in REDIR: IDLE next cycle, `redirect_valid`=0. No strobes fire in the reset cycle.

## Configuration
- `EXC_COMMIT_CTRL_STATS_EN` defined adds two outputs:
  - `exc_cnt` (32): counts EXC commits.
  - `int_cnt` (32): counts INT commits.
  - Each counter increments by 1 at its commit edge and wraps from 32'hffffffff to 0.
- Undefined: the ports and counters are absent. All other behaviour is identical.

## Test plan
- Plain CSRW: `wb_valid`=1, `wb_csr_we_in`=1, num=14'h30, mask=32'hffffffff, value=32'h1234 → `csr_we`=1 for one cycle with those values; `redirect_valid` stays 0; `wb_ready`=1 every cycle.
- EXC with stall: `csr_eentry_data`=32'h1c008000, `wb_ex_req`=1, ecode=6'h0b, pc=32'h1c000100, `redirect_ready` low 3 cycles → `wb_ex`=1 at T; `redirect_valid`=1 with `redirect_pc`=32'h1c008000 for T+1..T+4; IDLE at T+5.
- ERTN: `csr_era_pc`=32'h1c000104, `wb_ertn`=1, `redirect_ready`=1 → `ertn_flush`=1 at T; `redirect_pc`=32'h1c000104 at T+1; IDLE at T+2.
- Priority: `has_int`=1, `wb_ex_req`=1, `wb_csr_we_in`=1 in one commit → `wb_ex`=1, ecode=6'h00, `csr_we`=0.
- Reset mid-REDIR: `reset`=1 at T+2 of an EXC flush → `redirect_valid`=0 and `wb_ready`=1 at T+3; `exc_cnt`=0 with `EXC_COMMIT_CTRL_STATS_EN` defined.
- Counter wrap (`EXC_COMMIT_CTRL_STATS_EN` defined): force `int_cnt` to 32'hffffffff, one INT commit → `int_cnt`=0.
